// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO with a valid/ready write
// port feeding a start/data/stop serialiser. The line output comes straight
// from a flop and idles high.
module uart_tx_fifo #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [NW-1:0] OCC_FULL = NW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q;
  logic          full, empty, push, pop, cnt_end;

  // Occupancy alone decides readiness, so a write is refused whenever the
  // FIFO was full at the start of the cycle, even if the FSM pops this edge.
  assign full     = (count_q == OCC_FULL);
  assign empty    = (count_q == '0);
  assign push     = tx_valid && !full;
  assign tx_ready = !full;
  assign busy     = (state_q != IDLE) || !empty;
  assign tx       = tx_q;
  assign cnt_end  = (cnt_q == CNT_LAST);

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // FIFO pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + NW'(1);
        2'b01:   count_q <= count_q - NW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Serialiser next-state: each line bit lasts DIV cycles; the STOP bit's last
  // cycle chains straight into the next START when another byte is waiting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          shift_d = mem_q[rd_ptr_q];
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (!empty) begin
            shift_d = mem_q[rd_ptr_q];
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is computed from the next state so the pin flop changes on
    // the same edge the state does.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Serialiser registers; reset forces the line high and aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a fast instance (DIV=10) checked cycle by cycle
// against a queue-and-frame-timing reference model, plus a default-parameter
// instance whose bit and frame periods are measured on the line.
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;
  localparam int DDIV  = 100000000 / 115200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [7:0] d_tx_data = 8'h00;
  logic       d_tx_valid = 1'b0;
  logic       d_tx_ready, d_tx, d_busy;

  uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy));

  uart_tx_fifo dut_def (
    .clk(clk), .rst(rst), .tx_data(d_tx_data), .tx_valid(d_tx_valid),
    .tx_ready(d_tx_ready), .tx(d_tx), .busy(d_busy));

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a byte queue plus the edge at which the current frame
  // was popped; the line level follows from elapsed time / DIV.
  logic [7:0] mq[$];
  logic       m_active = 1'b0;
  int         m_pop_t = 0, m_end = 0, m_off;
  logic [7:0] m_cur = 8'h00;
  logic       m_full0;
  logic       exp_tx = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_active  = 1'b0;
      exp_tx    = 1'b1;
      exp_ready = 1'b1;
      exp_busy  = 1'b0;
    end else begin
      cyc++;
      m_full0 = (mq.size() == DEPTH);
      if (m_active && cyc == m_end) m_active = 1'b0;
      if (!m_active && mq.size() > 0) begin
        m_cur    = mq.pop_front();
        m_pop_t  = cyc;
        m_end    = cyc + FRAME;
        m_active = 1'b1;
      end
      if (tx_valid && !m_full0) mq.push_back(tx_data);
      exp_ready = (mq.size() < DEPTH);
      exp_busy  = m_active || (mq.size() > 0);
      exp_tx    = 1'b1;
      if (m_active) begin
        m_off = (cyc - m_pop_t) / DIV;
        if (m_off == 0)      exp_tx = 1'b0;
        else if (m_off <= 8) exp_tx = m_cur[m_off-1];
      end
    end
  end

  // Producer: presents src_q bytes, holding each until accepted.
  logic [7:0] src_q[$];
  logic       rdy_prev = 1'b1;
  logic       from_src = 1'b0;
  logic       manual   = 1'b0;
  int         gap_pct  = 0;

  task automatic advance();
    logic acc;
    @(negedge clk);
    acc = tx_valid && rdy_prev && from_src;
    if (acc) void'(src_q.pop_front());
    if (!manual) begin
      if (!(tx_valid && from_src && !acc)) begin
        if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
          tx_valid = 1'b1;
          tx_data  = src_q[0];
          from_src = 1'b1;
        end else begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
          from_src = 1'b0;
        end
      end
    end
    rdy_prev = tx_ready;
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    tx_valid   = 1'b0;
    d_tx_valid = 1'b0;
    manual     = 1'b0;
    from_src   = 1'b0;
    gap_pct    = 0;
    src_q.delete();
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    rdy_prev = tx_ready;
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++;
    if ({tx, tx_ready, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_values got tx/rdy/busy=%b%b%b want 110", tx, tx_ready, busy);
    end
    n_checks++;
    if ({d_tx, d_tx_ready, d_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_values_def got tx/rdy/busy=%b%b%b want 110", d_tx, d_tx_ready, d_busy);
    end
    src_q = '{8'h81, 8'h42, 8'h24, 8'h18};
    for (int i = 0; i < 40; i++) begin
      advance();
      n_checks++;
      if ({tx, tx_ready, busy} !== {exp_tx, exp_ready, exp_busy}) begin
        n_fail++;
        $display("FAIL reset_prefill cyc=%0d got %b%b%b want %b%b%b", cyc, tx, tx_ready, busy, exp_tx, exp_ready, exp_busy);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({tx, tx_ready, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_midframe got tx/rdy/busy=%b%b%b want 110", tx, tx_ready, busy);
    end
    src_q.delete();
    tx_valid = 1'b0;
    from_src = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    rdy_prev = tx_ready;
    for (int i = 0; i < 50; i++) begin
      advance();
      n_checks++;
      if ({tx, busy} !== 2'b10 || {tx, tx_ready, busy} !== {exp_tx, exp_ready, exp_busy}) begin
        n_fail++;
        $display("FAIL reset_quiet cyc=%0d got tx/rdy/busy=%b%b%b want 110", cyc, tx, tx_ready, busy);
      end
    end
  endtask

  task automatic test_single_byte();
    logic want;
    reset_dut();
    src_q = '{8'h55};
    advance();
    advance();
    n_checks++;
    if ({tx, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_accept got tx/busy=%b%b want 11", tx, busy);
    end
    advance();
    for (int k = 0; k < FRAME; k++) begin
      want = ((k / DIV) % 2 == 1);
      n_checks++;
      if ({tx, busy} !== {want, 1'b1} || {tx, tx_ready, busy} !== {exp_tx, exp_ready, exp_busy}) begin
        n_fail++;
        $display("FAIL single_wave k=%0d got tx/busy=%b%b want %b1", k, tx, busy, want);
      end
      advance();
    end
    n_checks++;
    if ({tx, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_done got tx/busy=%b%b want 10", tx, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic       line [2*FRAME];
    logic [7:0] got, want;
    reset_dut();
    src_q = '{8'hA3, 8'h0F};
    for (int i = 0; i < 10 && tx !== 1'b0; i++) advance();
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start_timeout got tx=%b want 0", tx);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      line[k] = tx;
      n_checks++;
      if ({tx, tx_ready, busy} !== {exp_tx, exp_ready, exp_busy}) begin
        n_fail++;
        $display("FAIL b2b_wave k=%0d got %b%b%b want %b%b%b", k, tx, tx_ready, busy, exp_tx, exp_ready, exp_busy);
      end
      advance();
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_total got busy=%b want 0 after 200 cycles", busy);
    end
    n_checks++;
    if ({line[FRAME-1], line[FRAME]} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_gap got stop/start=%b%b want 10", line[FRAME-1], line[FRAME]);
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) got[i] = line[f*FRAME + (i+1)*DIV + DIV/2];
      want = (f == 0) ? 8'hA3 : 8'h0F;
      n_checks++;
      if (got !== want || line[f*FRAME + DIV/2] !== 1'b0 || line[f*FRAME + 9*DIV + DIV/2] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_decode frame=%0d got %h want %h", f, got, want);
      end
    end
  endtask

  task automatic test_full_fifo();
    int t_low, t_high;
    reset_dut();
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    t_low  = -1;
    t_high = -1;
    for (int i = 0; i < 7 * FRAME; i++) begin
      advance();
      if (tx_ready === 1'b0 && t_low < 0) t_low = cyc;
      if (tx_ready === 1'b1 && t_low >= 0 && t_high < 0) t_high = cyc;
      n_checks++;
      if ({tx, tx_ready, busy} !== {exp_tx, exp_ready, exp_busy}) begin
        n_fail++;
        $display("FAIL full_wave cyc=%0d got %b%b%b want %b%b%b", cyc, tx, tx_ready, busy, exp_tx, exp_ready, exp_busy);
      end
    end
    n_checks++;
    if (t_low < 0 || t_high - t_low != FRAME - 3) begin
      n_fail++;
      $display("FAIL full_stall got %0d cycles not ready want %0d", t_high - t_low, FRAME - 3);
    end
    n_checks++;
    if (busy !== 1'b0 || src_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain got busy=%b pending=%0d want 0 0", busy, src_q.size());
    end
  endtask

  task automatic test_drop();
    reset_dut();
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 20 && !(tx_ready === 1'b0 && src_q.size() == 0); i++) advance();
    manual   = 1'b1;
    from_src = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      advance();
      n_checks++;
      if (tx_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_ready got tx_ready=%b want 0", tx_ready);
      end
    end
    tx_valid = 1'b0;
    manual   = 1'b0;
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      advance();
      n_checks++;
      if ({tx, tx_ready, busy} !== {exp_tx, exp_ready, exp_busy}) begin
        n_fail++;
        $display("FAIL drop_wave cyc=%0d got %b%b%b want %b%b%b", cyc, tx, tx_ready, busy, exp_tx, exp_ready, exp_busy);
      end
    end
  endtask

  task automatic test_simul_write_pop();
    reset_dut();
    src_q = '{8'hC1, 8'hD2};
    for (int i = 0; i < 10 && tx !== 1'b0; i++) advance();
    for (int k = 0; k < FRAME - 1; k++) advance();
    manual   = 1'b1;
    from_src = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hE3;
    advance();
    n_checks++;
    if ({tx, tx_ready, busy} !== 3'b011 || {tx, tx_ready, busy} !== {exp_tx, exp_ready, exp_busy}) begin
      n_fail++;
      $display("FAIL simul_edge got tx/rdy/busy=%b%b%b want 011", tx, tx_ready, busy);
    end
    tx_valid = 1'b0;
    manual   = 1'b0;
    src_q = '{8'hF4, 8'hF5, 8'hF6, 8'hF7};
    advance();
    for (int i = 2; i <= 4; i++) begin
      advance();
      n_checks++;
      if (tx_ready !== (i < 4)) begin
        n_fail++;
        $display("FAIL simul_count step=%0d got tx_ready=%b want %b", i, tx_ready, (i < 4));
      end
    end
    for (int i = 0; i < 6 * FRAME + 10; i++) begin
      advance();
      n_checks++;
      if ({tx, tx_ready, busy} !== {exp_tx, exp_ready, exp_busy}) begin
        n_fail++;
        $display("FAIL simul_wave cyc=%0d got %b%b%b want %b%b%b", cyc, tx, tx_ready, busy, exp_tx, exp_ready, exp_busy);
      end
    end
  endtask

  task automatic test_random();
    int n;
    reset_dut();
    for (int i = 0; i < 30; i++) src_q.push_back(8'($urandom));
    n = 0;
    while (n < 6000 && (src_q.size() > 0 || busy !== 1'b0)) begin
      if (n % 200 == 0) gap_pct = $urandom_range(95);
      advance();
      n++;
      n_checks++;
      if ({tx, tx_ready, busy} !== {exp_tx, exp_ready, exp_busy}) begin
        n_fail++;
        $display("FAIL random_wave cyc=%0d got %b%b%b want %b%b%b", cyc, tx, tx_ready, busy, exp_tx, exp_ready, exp_busy);
      end
    end
    n_checks++;
    if (n >= 6000 || exp_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL random_timeout got cycles=%0d model_busy=%b want drained", n, exp_busy);
    end
    gap_pct = 0;
  endtask

  task automatic test_default_params();
    int   t0, last, t_end, nchg;
    logic prev;
    @(negedge clk);
    d_tx_data  = 8'h55;
    d_tx_valid = 1'b1;
    @(negedge clk);
    d_tx_valid = 1'b0;
    for (int i = 0; i < 5 && d_tx !== 1'b0; i++) @(negedge clk);
    n_checks++;
    if (d_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL def_start_timeout got tx=%b want 0", d_tx);
    end
    t0    = cyc;
    last  = cyc;
    prev  = 1'b0;
    nchg  = 0;
    t_end = -1;
    for (int i = 0; i < 10 * DDIV + 100; i++) begin
      @(negedge clk);
      if (d_tx !== prev) begin
        prev = d_tx;
        nchg++;
        n_checks++;
        if (cyc - last != DDIV) begin
          n_fail++;
          $display("FAIL def_bit_period edge=%0d got %0d want %0d", nchg, cyc - last, DDIV);
        end
        last = cyc;
      end
      if (d_busy === 1'b0) begin
        t_end = cyc;
        break;
      end
    end
    n_checks++;
    if (t_end - t0 != 10 * DDIV || nchg != 9) begin
      n_fail++;
      $display("FAIL def_frame got %0d cycles %0d edges want %0d cycles 9 edges", t_end - t0, nchg, 10 * DDIV);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_drop();
    test_simul_write_pop();
    test_random();
    test_default_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
